// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
//
// Sends one command byte to the keyboard using the request-to-send handshake:
// hold the clock low, place the start bit, release the clock, then shift data
// bits out on each device falling clock edge. The device's ACK or NACK is
// reported with a one-cycle tx_done pulse. Both PS/2 lines are open-drain; the
// *_oe outputs pull a line low when 1, and the tristates are built at top level.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   tx_data, tx_valid  command byte (LSB first) and request; accepted on tx_valid && tx_ready
//   tx_ready, busy     idle / transfer-in-progress, decoded from state
//   tx_done            one-cycle pulse at end of every transfer (including timeout)
//   tx_ack_ok          valid with tx_done: 1 = device ACK
//   tx_error           pulses with tx_done on NACK or timeout
//   ps2_clk_in/_data_in  raw asynchronous PS/2 lines
//   ps2_clk_oe/_data_oe  1 = pull the line low, 0 = release

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhMax = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StData,
    StParity,
    StStop,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            ack_q, ack_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            ack_ok_q, ack_ok_d;
  logic            error_q, error_d;

  // Synchronizers; lines idle high, so reset to 1 to avoid a false falling edge.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic clk_fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = StInhibit;
        end
      end

      StInhibit: begin
        if (inh_cnt_q == InhMax) begin
          // Start bit goes out as the clock is released: this is the RTS.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = StData;
        end else begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
        end
      end

      default: begin
        // Device-clocked phase, bounded by the timeout; timeout wins over an edge.
        to_cnt_d = to_cnt_q + ToW'(1);
        if (to_cnt_q == ToMax) begin
          to_cnt_d  = to_cnt_q;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          case (state_q)
            StData: begin
              if (clk_fall) begin
                data_oe_d = ~shift_q[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  state_d = StParity;
                end
              end
            end
            StParity: begin
              if (clk_fall) begin
                data_oe_d = ~parity_q;
                state_d   = StStop;
              end
            end
            StStop: begin
              if (clk_fall) begin
                data_oe_d = 1'b0;
                state_d   = StAck;
              end
            end
            StAck: begin
              if (clk_fall) begin
                ack_d   = ~data_sync_q;
                state_d = StWaitIdle;
              end
            end
            StWaitIdle: begin
              if (clk_sync_q && data_sync_q) begin
                done_d   = 1'b1;
                ack_ok_d = ack_q;
                error_d  = ~ack_q;
                state_d  = StIdle;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
    end
  end

  assign tx_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign tx_done     = done_q;
  assign tx_ack_ok   = ack_ok_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
